// File: rtl/serial_compare_unit_if.sv
// serial_compare_unit_if
// Request/response bundle for the multi-cycle magnitude comparator.
//   master : ALU-side requester (drives start/is_signed/a/b, sees results)
//   slave  : comparator side (serial_compare_unit)
// Signals:
//   start     request strobe, honoured only while the comparator is not busy
//   is_signed 1 = two's-complement compare, 0 = unsigned
//   a, b      operands
//   busy      compare in progress
//   done      one-cycle completion pulse
//   result    set-less-than word {0..., lt}
//   lt/eq/gt  one-hot comparison flags (all zero only after reset)
interface serial_compare_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, result, lt, eq, gt
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, result, lt, eq, gt
    );
endinterface

// File: rtl/serial_compare_unit.sv
// serial_compare_unit
// Multi-cycle magnitude comparator. A start pulse latches a/b (signedness is
// folded in by flipping the operand MSBs), then the operands are scanned
// MSB-first DIGIT bits per cycle with a sticky lt/gt decision. On the last
// slice the flags and the set-less-than word are registered and done pulses.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous, active-high reset
//   bus   serial_compare_unit_if.slave request/response bundle
// Parameters:
//   WIDTH operand width, DIGIT bits compared per cycle (must divide WIDTH)
// Optional feature:
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, the scan stops on the first
//   differing slice; results and handshake are unchanged, only latency.
module serial_compare_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_compare_unit_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_compare_unit: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dlt_q, dlt_d, dgt_q, dgt_d;   // running decision
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

    logic [DIGIT-1:0] slice_a, slice_b;
    logic             nxt_lt, nxt_gt, finish, latch;

    // Current slice always sits at the top of the operand registers; they
    // shift left by DIGIT each RUN cycle.
    always_comb begin
        slice_a = a_q[WIDTH-1 -: DIGIT];
        slice_b = b_q[WIDTH-1 -: DIGIT];
        nxt_lt  = dlt_q | (~dgt_q & (slice_a < slice_b));
        nxt_gt  = dgt_q | (~dlt_q & (slice_a > slice_b));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish  = (cnt_q == '0) | nxt_lt | nxt_gt;
`else
        finish  = (cnt_q == '0);
`endif
        // Accepted in IDLE and DONE, ignored while RUN (busy).
        latch   = (state_q != RUN) && bus.start;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (finish)    state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy   = (state_q == RUN);
        bus.done   = (state_q == DONE);
        bus.lt     = lt_q;
        bus.eq     = eq_q;
        bus.gt     = gt_q;
        bus.result = {{(WIDTH-1){1'b0}}, lt_q};
    end

    // Datapath next values
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        dlt_d = dlt_q;
        dgt_d = dgt_q;
        lt_d  = lt_q;
        eq_d  = eq_q;
        gt_d  = gt_q;
        if (latch) begin
            // Flipping both MSBs maps two's-complement order onto unsigned order.
            a_d   = bus.a ^ (bus.is_signed ? MSB_MASK : '0);
            b_d   = bus.b ^ (bus.is_signed ? MSB_MASK : '0);
            cnt_d = CW'(N - 1);
            dlt_d = 1'b0;
            dgt_d = 1'b0;
        end else if (state_q == RUN) begin
            a_d   = a_q << DIGIT;
            b_d   = b_q << DIGIT;
            cnt_d = cnt_q - CW'(1);
            dlt_d = nxt_lt;
            dgt_d = nxt_gt;
            if (finish) begin
                lt_d = nxt_lt;
                gt_d = nxt_gt;
                eq_d = ~(nxt_lt | nxt_gt);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            dlt_q <= 1'b0;
            dgt_q <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            dlt_q <= dlt_d;
            dgt_q <= dgt_d;
            lt_q  <= lt_d;
            eq_q  <= eq_d;
            gt_q  <= gt_d;
        end
    end
endmodule

// File: tb/tb_serial_compare_unit.sv
// tb_serial_compare_unit
// Self-checking bench for serial_compare_unit (WIDTH=32, DIGIT=1): a table of
// directed vectors, hand-written multi-cycle sequences (start while busy,
// back-to-back, async reset mid-run) and random compares checked against a
// plain-arithmetic reference model. Latency expectation follows
// SERIAL_CMP_EARLY_EXIT_EN when it is defined for the build.
module tb_serial_compare_unit;
    localparam int WIDTH = 32;
    localparam int DIGIT = 1;
    localparam int N     = WIDTH / DIGIT;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_compare_unit_if #(.WIDTH(WIDTH)) bus ();

    serial_compare_unit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [2:0]       exp_f;   // {lt, eq, gt}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: ordering from plain integer comparison.
    function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic s);
        logic l, g;
        l = s ? ($signed(x) < $signed(y)) : (x < y);
        g = s ? ($signed(x) > $signed(y)) : (x > y);
        return {l, (x == y), g};
    endfunction

    // Edges from the start-sampling edge to done.
    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int first;
        first = N;
        for (int k = N - 1; k >= 0; k--)
            if (x[WIDTH-1-k*DIGIT -: DIGIT] != y[WIDTH-1-k*DIGIT -: DIGIT]) first = k;
        return (EARLY && first < N) ? first + 1 : N;
    endfunction

    // Must be called at a negedge; returns at the negedge where done is seen.
    task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                           input logic ts, input logic [2:0] exp_f, input string nm);
        int   lat;
        logic seen, bad_busy;
        bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.is_signed = ts;
        @(negedge clk);
        // Scramble inputs to show the operands were latched.
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.is_signed = 1'($urandom);
        lat = 0; seen = 1'b0; bad_busy = !bus.busy;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
            else if (!bus.busy) bad_busy = 1'b1;
        end
        check({nm, " latency"}, 64'(lat), 64'(exp_lat(ta, tb_v)));
        check({nm, " busy during run"}, 64'(bad_busy), 64'd0);
        check({nm, " flags/result"}, {29'd0, bus.lt, bus.eq, bus.gt, bus.result},
              {29'd0, exp_f, {(WIDTH-1){1'b0}}, exp_f[2]});
    endtask

    initial begin
        int dones, lat;
        logic [2:0] got_f;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 3'b100};
        vecs[1]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 3'b010};
        vecs[2]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 3'b100};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100};
        vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001};
        vecs[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 3'b001};
        vecs[7]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b010};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'b001};
        vecs[9]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 3'b001};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010};
        vecs[11] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 3'b100};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
        reset = 1'b1;
        #1;
        check("reset state", {26'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.result}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed table, with one idle cycle after each to check done and hold.
        foreach (vecs[i]) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_f, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d hold", i), {59'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt},
                  {59'd0, 2'b00, vecs[i].exp_f});
        end

        // start re-pulsed with new operands while busy: one done, first result.
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd3; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; lat = -1; got_f = 3'b000;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5 || c == 20) begin
                bus.start = 1'b1; bus.a = 32'd0; bus.b = 32'd9; bus.is_signed = 1'b1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin lat = c; got_f = {bus.lt, bus.eq, bus.gt}; end
            end
        end
        check("busy-start done count", 64'(dones), 64'd1);
        check("busy-start latency", 64'(lat), 64'(exp_lat(32'd5, 32'd3)));
        check("busy-start flags", 64'(got_f), 64'(3'b001));

        // Back-to-back: second start issued during the DONE cycle.
        run_cmp(32'd7, 32'd7, 1'b0, 3'b010, "b2b first");
        run_cmp(32'd1, 32'd2, 1'b0, 3'b100, "b2b second");
        @(negedge clk);

        // Async reset in the middle of a run.
        bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd4; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid-run reset", {26'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("post-reset no done", 64'(dones), 64'd0);
        run_cmp(32'd3, 32'd4, 1'b0, 3'b100, "post-reset cmp");
        @(negedge clk);

        // Random compares against the model; bias toward equal/near-equal.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_cmp(ra, rb, rs, model_flags(ra, rb, rs), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_compare_unit.md
Name: serial_compare_unit

Overview:
Multi-cycle magnitude comparator for the ALU comparison path. It accepts a compare request (a, b, signedness) on a start pulse and scans the operands MSB-first, DIGIT bits per cycle. It returns the set-less-than word and lt/eq/gt flags with a one-cycle done pulse. It is the responder side of the ALU compare request and serves the multi-cycle datapath, where a single-cycle 32-bit comparator is not wanted.

Parameters:
WIDTH, 32, operand width in bits
DIGIT, 1, bits compared per cycle; must divide WIDTH; N = WIDTH/DIGIT

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only when not busy
is_signed  input  1  1 = two's-complement compare, 0 = unsigned
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse; result and flags valid from this cycle on
result  output  WIDTH  set-less-than word: {WIDTH-1 zeros, lt}
lt  output  1  a < b
eq  output  1  a == b
gt  output  1  a > b

Behaviour:
- Reset (async, active-high): state=IDLE. busy=0, done=0, result=0, lt=0, eq=0, gt=0. Operand and digit-count registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b and is_signed into internal registers. The block enters RUN with the digit counter = N-1 and busy=1.
- Signed mode: the operand MSBs are inverted at latch time. An unsigned scan then gives the signed order.
- RUN: each edge compares one DIGIT-bit slice, MSB slice first.
  - Sticky decision: while the running decision is still "equal so far", a slice with a>b sets decision=GT and a slice with a<b sets decision=LT.
  - Once the decision is LT or GT it never changes.
  - The counter decrements by one per edge.
- Finish: on the edge that processes slice 0, the block registers lt/eq/gt and result = {0…, lt}, pulses done=1, clears busy and enters DONE.
- Latency: N edges from the start-sampling edge to done high. WIDTH=32, DIGIT=1 gives 32; DIGIT=4 gives 8.
- DONE: lasts one cycle. Next state is IDLE, or RUN if start=1 in this cycle, which allows back-to-back requests.
- Outputs hold: result/lt/eq/gt hold their values until the next finish. They do not change during a later RUN.
- Exactly one of lt/eq/gt is 1 after the first finish. All three are 0 only after reset.
- start while busy: ignored. The latched operands are unaffected and no second done is produced.
- a/b/is_signed changes during RUN: no effect, because operands are latched.
- Reset mid-RUN: immediate return to IDLE with all outputs at reset values. No done pulse.
- WIDTH not a multiple of DIGIT: elaboration error.

Optional Feature:
Macro: SERIAL_CMP_EARLY_EXIT_EN
- Defined: RUN terminates on the edge whose slice first produces a non-equal decision. done pulses on that edge and the remaining slices are skipped. Latency = k+1 edges, where k is the index (from MSB, 0-based) of the first differing slice. Equal operands still take N edges.
- Undefined: fixed latency of N edges for every compare.
- In both cases result, flags and handshake are identical; only timing differs.

Test Plan:
1. Unsigned, a=0, b=1, start 1 cycle -> busy=1 for 32 cycles, then done pulse; lt=1, eq=0, gt=0, result=32'h00000001.
2. Unsigned, a=1, b=1 -> done after 32 cycles; eq=1, lt=0, gt=0, result=0. Then a=1, b=2 -> lt=1, result=1.
3. a=32'hFFFFFFFF, b=1: is_signed=1 -> lt=1, result=1; is_signed=0 -> gt=1, result=0. Also a=32'h80000000, b=32'h7FFFFFFF signed -> lt=1.
4. start pulsed again at cycles 5 and 20 of a RUN, with new operands on a/b -> exactly one done at cycle 32, carrying the first operands' result. start held during DONE -> the second compare begins immediately and its done follows 32 cycles later.
5. reset asserted at cycle 10 of a RUN -> busy, done, lt, eq, gt and result go to 0 at once (async). No done follows. A new start after release gives a correct result.
6. With SERIAL_CMP_EARLY_EXIT_EN defined: a=32'h80000000, b=0 unsigned -> done 1 cycle after start, gt=1; a=b=32'h12345678 -> done after 32 cycles, eq=1. Without the macro, both cases take 32 cycles.
